// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of command, ALU-drive and response signals between the sequencer
// and its environment (command producer, ALU, response consumer).
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             c1;
  logic             c2;
  logic             c3;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             zero1;
  logic             zero2;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_z1;
  logic             rsp_z2;
  logic [7:0]       rsp_seq;
  logic [7:0]       zcnt1;
  logic [7:0]       zcnt2;

  // Sequencer side
  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, zero1, zero2, rsp_ready,
    output cmd_ready, c1, c2, c3, opA, opB,
    output rsp_valid, rsp_z1, rsp_z2, rsp_seq, zcnt1, zcnt2
  );

  // Environment side
  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, zero1, zero2, rsp_ready,
    input  cmd_ready, c1, c2, c3, opA, opB,
    input  rsp_valid, rsp_z1, rsp_z2, rsp_seq, zcnt1, zcnt2
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command front end for the dual-result ALU: queues {op,a,b} requests,
// drives the ALU from registers, captures zero1/zero2 one cycle after issue
// and returns them with a sequence number on a valid/ready channel.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                reset,
  alu_cmd_sequencer_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 3 + 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t        state;
  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [EW-1:0] head;
  logic [7:0]    seq_cnt;
  logic          full;
  logic          empty;
  logic          push;
  logic          issue;

  // Counter increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic hit);
    if (hit && cnt != 8'hFF)
      return cnt + 8'd1;
    return cnt;
  endfunction

  // Extra pointer MSB separates full (MSBs differ) from empty (equal)
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) &&
                         (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign issue         = !empty &&
                         ((state == IDLE) || (state == RESP && bus.rsp_ready));
  assign head          = mem[rd_ptr[AW-1:0]];

  // Command storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
  end

  // FIFO pointers: push at tail, pop on every issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (issue)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Issue/capture/respond FSM with registered ALU drive and response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.c1        <= 1'b0;
      bus.c2        <= 1'b0;
      bus.c3        <= 1'b0;
      bus.opA       <= '0;
      bus.opB       <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_z1    <= 1'b0;
      bus.rsp_z2    <= 1'b0;
      bus.rsp_seq   <= 8'd0;
      bus.zcnt1     <= 8'd0;
      bus.zcnt2     <= 8'd0;
      seq_cnt       <= 8'd0;
    end else begin
      // ALU lines change only on an issue edge and hold otherwise
      if (issue)
        {bus.c1, bus.c2, bus.c3, bus.opA, bus.opB} <= head;
      case (state)
        IDLE: begin
          if (!empty)
            state <= DRIVE;
        end
        DRIVE: begin
          bus.rsp_z1    <= bus.zero1;
          bus.rsp_z2    <= bus.zero2;
          bus.rsp_seq   <= seq_cnt;
          seq_cnt       <= seq_cnt + 8'd1;
          bus.zcnt1     <= sat_inc(bus.zcnt1, bus.zero1);
          bus.zcnt2     <= sat_inc(bus.zcnt2, bus.zero2);
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= empty ? IDLE : DRIVE;
          end
        end
        default: begin
          bus.rsp_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end
endmodule
